// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the shared half-precision divider controller.
package div_pkg;

    localparam int unsigned FP16_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } div_state_e;

    localparam logic [FP16_W-1:0] FP16_ONE  = 16'h3C00;
    localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;
    localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;
    localparam logic [4:0]        FP16_EMAX = 5'h1F;

endpackage

// File: rtl/div_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above the pointer, with wrap.
module div_rr_arbiter
    import div_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx
);

    logic            found;
    logic [ID_W-1:0] cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = ID_W'((32'(i_ptr) + off) % NUM_REQ);
            if (!found && i_req[cand]) begin
                found         = 1'b1;
                o_grant[cand] = 1'b1;
                o_idx         = cand;
            end
        end
    end

endmodule

// File: rtl/divhalfprecision.sv
// Combinational FP16 divider: round-to-nearest-even, subnormals flushed to zero.
// o_Exception flags NaN results, divide-by-zero and overflow.
module divhalfprecision
    import div_pkg::*;
(
    input  logic [FP16_W-1:0] i_Dividend,
    input  logic [FP16_W-1:0] i_Divisor,
    output logic [FP16_W-1:0] o_Quotient,
    output logic              o_Exception
);

    logic              sgn;
    logic [4:0]        exp_a, exp_b;
    logic [9:0]        frac_a, frac_b;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [10:0]       man_a, man_b;
    logic [13:0]       quo;
    logic [11:0]       rem;
    logic [10:0]       mant;
    logic              guard, sticky, round_up;
    logic [11:0]       mant_r;
    logic signed [7:0] exp_q;

    always_comb begin
        sgn      = i_Dividend[15] ^ i_Divisor[15];
        exp_a    = i_Dividend[14:10];
        exp_b    = i_Divisor[14:10];
        frac_a   = i_Dividend[9:0];
        frac_b   = i_Divisor[9:0];
        a_nan    = (exp_a == FP16_EMAX) && (frac_a != '0);
        b_nan    = (exp_b == FP16_EMAX) && (frac_b != '0);
        a_inf    = (exp_a == FP16_EMAX) && (frac_a == '0);
        b_inf    = (exp_b == FP16_EMAX) && (frac_b == '0);
        a_zero   = (exp_a == '0);
        b_zero   = (exp_b == '0);
        man_a    = {1'b1, frac_a};
        man_b    = {1'b1, frac_b};

        // Restoring division of man_a*2^13 by man_b; man_a < 2*man_b so 14 bits suffice.
        rem = {1'b0, man_a};
        quo = '0;
        for (int unsigned i = 0; i < 14; i++) begin
            if (i != 0) begin
                rem = {rem[10:0], 1'b0};
            end
            if (rem >= {1'b0, man_b}) begin
                rem = rem - {1'b0, man_b};
                quo = {quo[12:0], 1'b1};
            end else begin
                quo = {quo[12:0], 1'b0};
            end
        end

        exp_q = $signed({3'b000, exp_a}) - $signed({3'b000, exp_b}) + 8'sd15;
        if (quo[13]) begin
            mant   = quo[13:3];
            guard  = quo[2];
            sticky = (|quo[1:0]) | (|rem);
        end else begin
            mant   = quo[12:2];
            guard  = quo[1];
            sticky = quo[0] | (|rem);
            exp_q  = exp_q - 8'sd1;
        end
        round_up = guard & (sticky | mant[0]);
        mant_r   = {1'b0, mant} + {11'b0, round_up};
        if (mant_r[11]) begin
            exp_q = exp_q + 8'sd1;
        end

        o_Quotient  = FP16_ZERO;
        o_Exception = 1'b0;
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
            o_Quotient  = FP16_QNAN;
            o_Exception = 1'b1;
        end else if (a_inf) begin
            o_Quotient  = {sgn, FP16_EMAX, 10'b0};
        end else if (b_zero) begin
            o_Quotient  = {sgn, FP16_EMAX, 10'b0};
            o_Exception = 1'b1;
        end else if (b_inf || a_zero) begin
            o_Quotient  = {sgn, 15'b0};
        end else if (exp_q >= 8'sd31) begin
            o_Quotient  = {sgn, FP16_EMAX, 10'b0};
            o_Exception = 1'b1;
        end else if (exp_q <= 8'sd0) begin
            o_Quotient  = {sgn, 15'b0};
        end else begin
            o_Quotient  = {sgn, exp_q[4:0], (mant_r[11] ? 10'b0 : mant_r[9:0])};
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// Round-robin scheduler sharing one combinational FP16 divider among NUM_REQ requesters.
module div_share_ctrl
    import div_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DIV_LATENCY = 1,
    parameter int unsigned ID_W        = $clog2(NUM_REQ)
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_n,
    input  logic [NUM_REQ-1:0]        i_Req_Valid,
    input  logic [FP16_W*NUM_REQ-1:0] i_Req_Dividend,
    input  logic [FP16_W*NUM_REQ-1:0] i_Req_Divisor,
    output logic [NUM_REQ-1:0]        o_Req_Ready,
    output logic                      o_Resp_Valid,
    output logic [FP16_W-1:0]         o_Resp_Quotient,
    output logic                      o_Resp_Exception,
    output logic [ID_W-1:0]           o_Resp_Id,
    input  logic                      i_Resp_Ready
);

    localparam int unsigned CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;

    div_state_e         state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [FP16_W-1:0]  dvd_q, dvd_d;
    logic [FP16_W-1:0]  dvs_q, dvs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               resp_valid_q, resp_valid_d;
    logic [FP16_W-1:0]  resp_quot_q, resp_quot_d;
    logic               resp_exc_q, resp_exc_d;
    logic [ID_W-1:0]    resp_id_q, resp_id_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0] req_ready;
    logic [FP16_W-1:0]  div_quot;
    logic               div_exc;

    div_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req   (i_Req_Valid),
        .i_ptr   (ptr_q),
        .o_grant (grant),
        .o_idx   (grant_idx)
    );

    // Only the registered operands reach the divider.
    divhalfprecision u_div (
        .i_Dividend  (dvd_q),
        .i_Divisor   (dvs_q),
        .o_Quotient  (div_quot),
        .o_Exception (div_exc)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        dvd_d        = dvd_q;
        dvs_d        = dvs_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        resp_quot_d  = resp_quot_q;
        resp_exc_d   = resp_exc_q;
        resp_id_d    = resp_id_q;
        req_ready    = '0;
        unique case (state_q)
            IDLE: begin
                // Ready is masked while reset is held so no grant is advertised then.
                req_ready = i_Rst_n ? grant : '0;
                if (|grant) begin
                    dvd_d   = i_Req_Dividend[FP16_W*32'(grant_idx) +: FP16_W];
                    dvs_d   = i_Req_Divisor[FP16_W*32'(grant_idx) +: FP16_W];
                    id_d    = grant_idx;
                    cnt_d   = CNT_W'(DIV_LATENCY - 1);
                    ptr_d   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    resp_quot_d  = div_quot;
                    resp_exc_d   = div_exc;
                    resp_id_d    = id_q;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (i_Resp_Ready && resp_valid_q) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            dvd_q        <= FP16_ZERO;
            dvs_q        <= FP16_ZERO;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_quot_q  <= FP16_ZERO;
            resp_exc_q   <= 1'b0;
            resp_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            dvd_q        <= dvd_d;
            dvs_q        <= dvs_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_quot_q  <= resp_quot_d;
            resp_exc_q   <= resp_exc_d;
            resp_id_q    <= resp_id_d;
        end
    end

    assign o_Req_Ready      = req_ready;
    assign o_Resp_Valid     = resp_valid_q;
    assign o_Resp_Quotient  = resp_quot_q;
    assign o_Resp_Exception = resp_exc_q;
    assign o_Resp_Id        = resp_id_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl: directed scenarios plus random traffic against a transaction-level model.
module tb_div_share_ctrl;

    localparam int NR  = 4;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [NR-1:0] req_valid = '0;
    logic [16*NR-1:0] req_dvd = '0;
    logic [16*NR-1:0] req_dvs = '0;
    logic [NR-1:0] req_ready;
    logic          resp_valid;
    logic [15:0]   resp_quot;
    logic          resp_exc;
    logic [1:0]    resp_id;
    logic          resp_ready = 1'b0;

    always #5 clk = ~clk;

    div_share_ctrl #(
        .NUM_REQ     (NR),
        .DIV_LATENCY (LAT)
    ) dut (
        .i_Clk            (clk),
        .i_Rst_n          (rst_n),
        .i_Req_Valid      (req_valid),
        .i_Req_Dividend   (req_dvd),
        .i_Req_Divisor    (req_dvs),
        .o_Req_Ready      (req_ready),
        .o_Resp_Valid     (resp_valid),
        .o_Resp_Quotient  (resp_quot),
        .o_Resp_Exception (resp_exc),
        .o_Resp_Id        (resp_id),
        .i_Resp_Ready     (resp_ready)
    );

    typedef struct {
        int          id;
        logic [15:0] q;
        logic        exc;
    } exp_t;

    exp_t        exp_q[$];
    int          acc_ids[$];
    int          acc_cyc[$];
    int          rec_id[$];
    logic [15:0] rec_q[$];
    logic        rec_exc[$];

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   m_ptr = 0;
    int   m_cnt = 0;
    bit   m_busy = 0;
    bit   m_rv = 0;
    int   g_last = -1;
    bit   auto_drop = 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference FP16 divide from the arithmetic definition: {exception, quotient}.
    function automatic logic [16:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, fa, fb, ma, mb, s, q, r, e;
        logic sg;
        bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        sg = a[15] ^ b[15];
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        fa = int'(a[9:0]);   fb = int'(b[9:0]);
        a_nan = (ea == 31) && (fa != 0); b_nan = (eb == 31) && (fb != 0);
        a_inf = (ea == 31) && (fa == 0); b_inf = (eb == 31) && (fb == 0);
        a_zero = (ea == 0); b_zero = (eb == 0);
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) return {1'b1, 16'h7E00};
        if (a_inf) return {1'b0, sg, 15'h7C00};
        if (b_zero) return {1'b1, sg, 15'h7C00};
        if (b_inf || a_zero) return {1'b0, sg, 15'h0000};
        ma = 1024 + fa;
        mb = 1024 + fb;
        s = (ma >= mb) ? 10 : 11;
        q = (ma << s) / mb;
        r = (ma << s) % mb;
        if ((2 * r > mb) || ((2 * r == mb) && (q % 2 == 1))) q++;
        e = ea - eb + 15 + 10 - s;
        if (q == 2048) begin
            q = 1024;
            e++;
        end
        if (e >= 31) return {1'b1, sg, 15'h7C00};
        if (e <= 0) return {1'b0, sg, 15'h0000};
        return {1'b0, sg, 5'(e), 10'(q - 1024)};
    endfunction

    function automatic logic [15:0] rand_fp();
        logic [15:0] sp [9] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00,
                                16'h3C00, 16'h0001, 16'h7BFF, 16'h0400};
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 8)];
        return 16'($urandom);
    endfunction

    task automatic set_req(input int k, input logic [15:0] a, input logic [15:0] b);
        req_dvd[k*16 +: 16] = a;
        req_dvs[k*16 +: 16] = b;
        req_valid[k] = 1'b1;
    endtask

    // One clock: check outputs against the model, advance the model across the edge.
    task automatic step();
        int g;
        logic [NR-1:0] exp_rdy;
        logic [16:0] res;
        exp_t e;
        #1;
        g = -1;
        if (!m_busy) begin
            for (int k = 0; k < NR; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("resp_valid", 32'(resp_valid), 32'(m_rv));
        if (m_rv && exp_q.size() > 0) begin
            chk("resp_quot", 32'(resp_quot), 32'(exp_q[0].q));
            chk("resp_exc", 32'(resp_exc), 32'(exp_q[0].exc));
            chk("resp_id", 32'(resp_id), 32'(exp_q[0].id));
        end
        g_last = -1;
        if (g >= 0) begin
            res = ref_div(req_dvd[g*16 +: 16], req_dvs[g*16 +: 16]);
            e.id = g; e.q = res[15:0]; e.exc = res[16];
            exp_q.push_back(e);
            acc_ids.push_back(g);
            acc_cyc.push_back(cyc);
            m_busy = 1; m_cnt = 0; m_ptr = (g + 1) % NR;
            g_last = g;
        end else if (m_busy && !m_rv) begin
            m_cnt++;
            if (m_cnt == LAT) m_rv = 1;
        end else if (m_rv && resp_ready) begin
            rec_id.push_back(int'(resp_id));
            rec_q.push_back(resp_quot);
            rec_exc.push_back(resp_exc);
            void'(exp_q.pop_front());
            m_busy = 0; m_rv = 0;
        end
        @(negedge clk);
        cyc++;
        if (auto_drop && g_last >= 0) req_valid[g_last] = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_busy = 0; m_rv = 0; m_cnt = 0; m_ptr = 0; g_last = -1;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_valid"}, 32'(resp_valid), 32'h0);
        chk({tag, "_quot"}, 32'(resp_quot), 32'h0);
        chk({tag, "_exc"}, 32'(resp_exc), 32'h0);
        chk({tag, "_id"}, 32'(resp_id), 32'h0);
    endtask

    // Called at a negedge; returns at a negedge with reset released.
    task automatic do_reset();
        req_valid = '1;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        cyc += 2;
        req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic run_resp(input string tag, input int budget);
        int n0;
        int left;
        n0 = rec_q.size();
        left = budget;
        while (rec_q.size() == n0 && left > 0) begin
            step();
            left--;
        end
        if (rec_q.size() == n0) chk({tag, "_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic drain();
        int left;
        left = 40;
        resp_ready = 1'b1;
        while (m_busy && left > 0) begin
            step();
            left--;
        end
        if (m_busy) chk("drain_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, left, rc;
        @(negedge clk);
        do_reset();

        // Basic divide 2.0/1.0 from requester 0.
        resp_ready = 1'b1;
        set_req(0, 16'h4000, 16'h3C00);
        run_resp("basic", 20);
        chk("basic_q", 32'(rec_q[$]), 32'h4000);
        chk("basic_exc", 32'(rec_exc[$]), 32'h0);
        chk("basic_id", 32'(rec_id[$]), 32'h0);

        // 3.0/2.0 from requester 1.
        set_req(1, 16'h4200, 16'h4000);
        run_resp("second", 20);
        chk("second_q", 32'(rec_q[$]), 32'h3E00);
        chk("second_id", 32'(rec_id[$]), 32'h1);

        // Divide by zero passes the divider exception through.
        set_req(2, 16'h3C00, 16'h0000);
        run_resp("exc", 20);
        chk("exc_flag", 32'(rec_exc[$]), 32'h1);
        chk("exc_id", 32'(rec_id[$]), 32'h2);

        // Round-robin fairness with all requesters valid from reset.
        do_reset();
        auto_drop = 0;
        for (int k = 0; k < NR; k++) set_req(k, rand_fp(), rand_fp());
        n0 = acc_ids.size();
        left = 60;
        while (acc_ids.size() < n0 + 5 && left > 0) begin
            step();
            left--;
        end
        if (acc_ids.size() < n0 + 5) begin
            chk("rr_timeout", 32'h0, 32'h1);
        end else begin
            for (int i = 0; i < 5; i++) chk("rr_order", 32'(acc_ids[n0 + i]), 32'(i % NR));
            for (int i = 1; i < 5; i++)
                chk("rr_interval", 32'(acc_cyc[n0 + i] - acc_cyc[n0 + i - 1]), 32'(LAT + 2));
        end
        req_valid = '0;
        auto_drop = 1;
        drain();

        // Backpressure in RESP, with other requests arriving meanwhile.
        resp_ready = 1'b0;
        set_req(0, 16'h4400, 16'h4000);
        left = 20;
        while (!m_rv && left > 0) begin
            step();
            left--;
        end
        if (!m_rv) chk("bp_timeout", 32'h0, 32'h1);
        for (int k = 1; k < NR; k++) set_req(k, rand_fp(), rand_fp());
        for (int i = 0; i < 5; i++) step();
        resp_ready = 1'b1;
        rc = cyc;
        step();
        step();
        chk("bp_next_grant", 32'(acc_cyc[$]), 32'(rc + 1));
        req_valid = '0;
        drain();

        // Reset asserted while an operation is in WAIT.
        set_req(1, 16'h4800, 16'h4200);
        step();
        chk("rst_inflight", 32'(m_busy && !m_rv), 32'h1);
        req_valid = '0;
        set_req(3, 16'h4600, 16'h4000);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("rst_mid");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        cyc += 2;
        rst_n = 1'b1;
        n0 = rec_q.size();
        run_resp("rst_recover", 20);
        chk("rst_id", 32'(rec_id[$]), 32'h3);
        for (int i = 0; i < 10; i++) step();
        chk("rst_no_stale", 32'(rec_q.size() - n0), 32'h1);

        // Random traffic: requesters hold until granted, sometimes withdraw while idle.
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < NR; k++) begin
                if (!req_valid[k] && $urandom_range(0, 2) == 0)
                    set_req(k, rand_fp(), rand_fp());
                else if (req_valid[k] && !m_busy && $urandom_range(0, 9) == 0)
                    req_valid[k] = 1'b0;
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = '0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Round-robin scheduler that shares one half-precision divider (divhalfprecision, combinational) among NUM_REQ requesters in the pipeline.
- Accepts one request at a time over a valid/ready handshake and registers the operands into the divider.
- Waits a fixed settle time, then captures quotient and exception into an output register.
- Returns the result with the requester ID over a valid/ready response channel.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DIV_LATENCY, 1, cycles the divider output is allowed to settle before capture (>=1).
- ID_W, $clog2(NUM_REQ), width of requester ID.

Ports:
- i_Clk  input  1  clock, rising edge.
- i_Rst_n  input  1  asynchronous reset, active-low.
- i_Req_Valid  input  NUM_REQ  per-requester request valid.
- i_Req_Dividend  input  16*NUM_REQ  packed FP16 dividends; requester k uses bits [16k+15:16k].
- i_Req_Divisor  input  16*NUM_REQ  packed FP16 divisors, same packing.
- o_Req_Ready  output  NUM_REQ  one-hot grant/ready.
- o_Resp_Valid  output  1  response valid.
- o_Resp_Quotient  output  16  FP16 quotient.
- o_Resp_Exception  output  1  divider exception flag.
- o_Resp_Id  output  ID_W  index of the requester that issued the operation.
- i_Resp_Ready  input  1  response consumer ready.

Behaviour:
- Reset (async, i_Rst_n=0):
  - state=IDLE, rr pointer=0, operand regs=0, wait counter=0.
  - o_Req_Ready=0, o_Resp_Valid=0, o_Resp_Quotient=0, o_Resp_Exception=0, o_Resp_Id=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Grant g = first asserted i_Req_Valid bit, searching upward from the rr pointer with wrap-around.
  - o_Req_Ready = onehot(g), combinational from i_Req_Valid and the pointer. o_Req_Ready=0 when no valid bit is set.
  - Accept occurs on an edge where i_Req_Valid[g]&o_Req_Ready[g]=1. On accept:
    - latch dividend, divisor and ID g;
    - counter <= DIV_LATENCY-1;
    - pointer <= (g+1) mod NUM_REQ;
    - go to WAIT.
- WAIT:
  - o_Req_Ready=0.
  - While counter!=0, decrement.
  - When counter==0, capture divider o_Quotient/o_Exception and the latched ID into the response regs, set o_Resp_Valid=1, go to RESP.
- RESP:
  - o_Req_Ready=0.
  - o_Resp_* are held stable until i_Resp_Ready=1 with o_Resp_Valid=1.
  - On that edge, o_Resp_Valid<=0 and go to IDLE. No grant is issued in that same cycle.
- Latency and throughput:
  - o_Resp_Valid rises DIV_LATENCY cycles after the accepting edge.
  - Minimum issue interval is DIV_LATENCY+2 cycles.
- Boundary conditions:
  - A requester dropping valid before it is granted: no accept and no side effect. The pointer changes only on accept.
  - Valid bits set while in WAIT/RESP are ignored; ready stays 0 and the requester must hold its request.
  - Exceptions (divide by zero, overflow, NaN) are passed through unchanged. The controller raises no exception of its own and never drops a response.
  - Pointer wrap: after granting NUM_REQ-1 the pointer becomes 0.
  - Reset asserted in WAIT or RESP: the in-flight operation is discarded and no response is produced.
  - The divider operand regs are the only divider inputs; requester inputs never drive the divider combinationally.

Decomposition:
- Shared package div_pkg:
  - FP16 width constant (16);
  - state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - FP16 constants ONE=16'h3C00 and ZERO=16'h0000.
- Sub-module div_rr_arbiter (NUM_REQ parameter; inputs req vector and pointer; outputs one-hot grant and encoded index). It is purely combinational. The pointer register lives in div_share_ctrl.
- divhalfprecision is instantiated once inside div_share_ctrl.

Test Plan:
- Basic divide: after reset, req0 sends 16'h4000/16'h3C00 (2.0/1.0), i_Resp_Ready=1 -> o_Resp_Valid exactly DIV_LATENCY cycles after accept, Quotient=16'h4000, Exception=0, Id=0.
- Second value: req1 sends 16'h4200/16'h4000 (3.0/2.0) -> Quotient=16'h3E00 (1.5), Id=1.
- Round-robin fairness: all 4 valid continuously from reset -> service order Id 0,1,2,3,0. Each accept is DIV_LATENCY+2 cycles apart. Exactly one o_Req_Ready bit is high per accept.
- Backpressure: i_Resp_Ready held low 5 cycles in RESP -> o_Resp_* unchanged every cycle and o_Req_Ready=0 throughout. Releasing ready retires the response, and the next grant follows the cycle after.
- Exception pass-through: req2 sends 16'h3C00/16'h0000 -> o_Resp_Exception equals the divider's o_Exception for those operands (1), with Id=2.
- Reset mid-operation: deassert i_Rst_n during WAIT -> all outputs 0 immediately. After release with req3 valid only, the pointer restarts at 0, req3 is granted, and no stale response appears.
